// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_pkg
// Purpose  : Shared types and defaults for the instruction fetch controller.
//            Holds the fetch FSM state encoding, the default reset PC and the
//            helper that sizes the optional fetch timeout counter.
// Revision : 1.0 - initial release
// ============================================================================
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_ERR  = 2'd2
  } if_state_t;

  localparam logic [31:0] DEF_RESET_PC       = 32'h0000_3000;
  localparam int          DEF_TIMEOUT_CYCLES = 16;

  // Counter must be able to hold the value TIMEOUT_CYCLES itself.
  function automatic int tmo_cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

  localparam int DEF_TMO_CNT_W = tmo_cnt_width(DEF_TIMEOUT_CYCLES);

endpackage
`default_nettype wire

// File: rtl/fetch_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module   : fetch_timeout_cnt
// Purpose  : Counts request cycles that pass without acknowledge and flags
//            the cycle in which the count would reach LIMIT.
// Ports    : CLK_I      - clock
//            Reset_N_I  - asynchronous active-low reset
//            Clear_I    - hold counter at zero (controller idle)
//            Enable_I   - one REQ cycle elapsed without acknowledge
//            Limit_O    - this un-acknowledged cycle is the LIMIT-th one
// Revision : 1.0 - initial release
// ============================================================================
module fetch_timeout_cnt #(
  parameter int WIDTH = 5,
  parameter int LIMIT = 16
) (
  input  logic CLK_I,
  input  logic Reset_N_I,
  input  logic Clear_I,
  input  logic Enable_I,
  output logic Limit_O
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge CLK_I or negedge Reset_N_I) begin
    if (!Reset_N_I) begin
      r_cnt <= '0;
    end else if (Clear_I) begin
      r_cnt <= '0;
    end else if (Enable_I) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Flag one cycle early so the controller leaves REQ on the edge that would
  // make the count equal LIMIT; an acknowledge in that cycle keeps Enable_I low.
  assign Limit_O = Enable_I && (r_cnt == WIDTH'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Instruction fetch controller for the multi-cycle MIPS-C datapath.
//            Owns the PC, reads the word at PC from instruction memory over a
//            req/ack handshake, pulses IRWrite_O for one cycle with the word
//            and advances the PC.
// Ports    : CLK_I, Reset_N_I (async active-low)
//            Fetch_I, PCWrite_I, NPC_I           - control unit side
//            Mem_Req_O, Mem_Addr_O, Mem_Ack_I,
//            Mem_Data_I                          - instruction memory side
//            IRWrite_O, IRData_O                 - instruction register side
//            PC_O, PC4_O, Busy_O, Err_O          - status
// Config   : FETCH_TIMEOUT_EN - when defined, a request left unacknowledged
//            for TIMEOUT_CYCLES cycles is abandoned and the controller enters
//            ERR. When undefined, REQ waits indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = DEF_RESET_PC,
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        CLK_I,
  input  logic        Reset_N_I,
  input  logic        Fetch_I,
  input  logic        PCWrite_I,
  input  logic [31:0] NPC_I,
  output logic        Mem_Req_O,
  output logic [31:0] Mem_Addr_O,
  input  logic        Mem_Ack_I,
  input  logic [31:0] Mem_Data_I,
  output logic        IRWrite_O,
  output logic [31:0] IRData_O,
  output logic [31:0] PC_O,
  output logic [31:0] PC4_O,
  output logic        Busy_O,
  output logic        Err_O
);

  if_state_t   r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [31:0] r_ir_data, w_ir_data_nxt;
  logic        r_ir_write, w_ir_write_nxt;
  logic        r_pc_written, w_pc_written_nxt;  // PCWrite seen during this fetch
  logic [31:0] w_eff_addr;
  logic        w_tmo_hit;

`ifdef FETCH_TIMEOUT_EN
  localparam int TMO_CNT_W = tmo_cnt_width(TIMEOUT_CYCLES);

  // Clearing while idle guarantees a zero count on every entry into REQ.
  fetch_timeout_cnt #(
    .WIDTH (TMO_CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmo (
    .CLK_I     (CLK_I),
    .Reset_N_I (Reset_N_I),
    .Clear_I   (r_state == IF_IDLE),
    .Enable_I  ((r_state == IF_REQ) && !Mem_Ack_I),
    .Limit_O   (w_tmo_hit)
  );
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
  assign w_tmo_hit    = 1'b0;
`endif

  // A same-cycle PCWrite redirects the fetch to the new PC.
  assign w_eff_addr = PCWrite_I ? NPC_I : r_pc;

  always_ff @(posedge CLK_I or negedge Reset_N_I) begin
    if (!Reset_N_I) begin
      r_state      <= IF_IDLE;
      r_pc         <= RESET_PC;
      r_addr       <= RESET_PC;
      r_ir_data    <= '0;
      r_ir_write   <= 1'b0;
      r_pc_written <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_addr       <= w_addr_nxt;
      r_ir_data    <= w_ir_data_nxt;
      r_ir_write   <= w_ir_write_nxt;
      r_pc_written <= w_pc_written_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_addr_nxt       = r_addr;
    w_ir_data_nxt    = r_ir_data;
    w_ir_write_nxt   = 1'b0;
    w_pc_written_nxt = r_pc_written;

    case (r_state)
      IF_IDLE: begin
        if (PCWrite_I) w_pc_nxt = NPC_I;
        if (Fetch_I) begin
          if (w_eff_addr[1:0] == 2'b00) begin
            w_addr_nxt       = w_eff_addr;
            w_pc_written_nxt = 1'b0;
            w_state_nxt      = IF_REQ;
          end else begin
            w_state_nxt      = IF_ERR;
          end
        end
      end
      IF_REQ: begin
        // Redirects land in PC at once; the outstanding address never moves.
        if (PCWrite_I) begin
          w_pc_nxt         = NPC_I;
          w_pc_written_nxt = 1'b1;
        end
        if (Mem_Ack_I) begin
          w_ir_data_nxt  = Mem_Data_I;
          w_ir_write_nxt = 1'b1;
          w_state_nxt    = IF_IDLE;
          if (!PCWrite_I && !r_pc_written) w_pc_nxt = r_addr + 32'd4;
        end else if (w_tmo_hit) begin
          w_state_nxt    = IF_ERR;
        end
      end
      IF_ERR: begin
        if (PCWrite_I) begin
          w_pc_nxt    = NPC_I;
          w_state_nxt = IF_IDLE;
        end
      end
      default: w_state_nxt = IF_IDLE;
    endcase
  end

  assign Mem_Req_O  = (r_state == IF_REQ);
  assign Busy_O     = (r_state == IF_REQ);
  assign Err_O      = (r_state == IF_ERR);
  assign Mem_Addr_O = r_addr;
  assign IRWrite_O  = r_ir_write;
  assign IRData_O   = r_ir_data;
  assign PC_O       = r_pc;
  assign PC4_O      = r_pc + 32'd4;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Self-checking bench for instr_fetch. Directed scenarios with
//            literal expectations, then randomized traffic checked every
//            cycle against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  localparam int TMO = 4;

  logic        CLK_I = 1'b0;
  logic        Reset_N_I;
  logic        Fetch_I, PCWrite_I, Mem_Ack_I;
  logic [31:0] NPC_I, Mem_Data_I;
  logic        Mem_Req_O, IRWrite_O, Busy_O, Err_O;
  logic [31:0] Mem_Addr_O, IRData_O, PC_O, PC4_O;

  int checks = 0;
  int errors = 0;

  always #5 CLK_I = ~CLK_I;

  instr_fetch #(.RESET_PC(32'h0000_3000), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK_I      (CLK_I),
    .Reset_N_I  (Reset_N_I),
    .Fetch_I    (Fetch_I),
    .PCWrite_I  (PCWrite_I),
    .NPC_I      (NPC_I),
    .Mem_Req_O  (Mem_Req_O),
    .Mem_Addr_O (Mem_Addr_O),
    .Mem_Ack_I  (Mem_Ack_I),
    .Mem_Data_I (Mem_Data_I),
    .IRWrite_O  (IRWrite_O),
    .IRData_O   (IRData_O),
    .PC_O       (PC_O),
    .PC4_O      (PC4_O),
    .Busy_O     (Busy_O),
    .Err_O      (Err_O)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic f, input logic pw, input logic [31:0] npc,
                       input logic ack, input logic [31:0] data);
    Fetch_I = f; PCWrite_I = pw; NPC_I = npc; Mem_Ack_I = ack; Mem_Data_I = data;
  endtask

  task automatic step();
    @(negedge CLK_I);
  endtask

  // Reference model: what a fetch controller must present after each edge.
  logic        m_busy, m_err, m_irw, m_written;
  logic [31:0] m_pc, m_addr, m_ird;
  int          m_cnt;

  task automatic model_reset();
    m_busy = 0; m_err = 0; m_irw = 0; m_written = 0;
    m_pc = 32'h3000; m_addr = 32'h3000; m_ird = 0; m_cnt = 0;
  endtask

  task automatic model_step(input logic f, input logic pw, input logic [31:0] npc,
                            input logic ack, input logic [31:0] data);
    logic [31:0] eff;
    m_irw = 0;
    if (m_busy) begin
      if (pw) begin m_pc = npc; m_written = 1; end
      if (ack) begin
        m_ird = data; m_irw = 1; m_busy = 0;
        if (!m_written) m_pc = m_addr + 32'd4;
      end else begin
`ifdef FETCH_TIMEOUT_EN
        m_cnt++;
        if (m_cnt == TMO) begin m_busy = 0; m_err = 1; end
`endif
      end
    end else if (m_err) begin
      if (pw) begin m_pc = npc; m_err = 0; end
    end else begin
      eff = pw ? npc : m_pc;
      if (pw) m_pc = npc;
      if (f) begin
        if (eff % 4 == 0) begin m_addr = eff; m_busy = 1; m_written = 0; m_cnt = 0; end
        else m_err = 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("req",   {31'd0, Mem_Req_O}, {31'd0, m_busy});
    chk("busy",  {31'd0, Busy_O},    {31'd0, m_busy});
    chk("err",   {31'd0, Err_O},     {31'd0, m_err});
    chk("irw",   {31'd0, IRWrite_O}, {31'd0, m_irw});
    chk("addr",  Mem_Addr_O, m_addr);
    chk("ird",   IRData_O,   m_ird);
    chk("pc",    PC_O,       m_pc);
    chk("pc4",   PC4_O,      m_pc + 32'd4);
  endtask

  initial begin
    logic        f, pw, ack;
    logic [31:0] npc, data, r;
    int          n;
    logic        saw_irw;

    drive(0, 0, 0, 0, 0);
    Reset_N_I = 1'b0;
    repeat (2) step();

    // Reset values
    chk("rst_pc",   PC_O,       32'h3000);
    chk("rst_pc4",  PC4_O,      32'h3004);
    chk("rst_addr", Mem_Addr_O, 32'h3000);
    chk("rst_req",  {31'd0, Mem_Req_O}, 0);
    chk("rst_irw",  {31'd0, IRWrite_O}, 0);
    chk("rst_ird",  IRData_O,   0);
    chk("rst_busy", {31'd0, Busy_O}, 0);
    chk("rst_err",  {31'd0, Err_O},  0);
    Reset_N_I = 1'b1;

    // Zero-wait fetch
    drive(1, 0, 0, 0, 0); step();
    chk("zw_req",  {31'd0, Mem_Req_O}, 1);
    chk("zw_addr", Mem_Addr_O, 32'h3000);
    drive(0, 0, 0, 1, 32'h2408_0005); step();
    chk("zw_irw", {31'd0, IRWrite_O}, 1);
    chk("zw_ird", IRData_O, 32'h2408_0005);
    chk("zw_pc",  PC_O, 32'h3004);
    chk("zw_req_drop", {31'd0, Mem_Req_O}, 0);
    drive(0, 0, 0, 0, 0); step();
    chk("zw_irw_end", {31'd0, IRWrite_O}, 0);
    chk("zw_ird_hold", IRData_O, 32'h2408_0005);

    // Three wait states; Fetch_I held high must be ignored while busy
    drive(1, 0, 0, 0, 0); step();
    n = 0; saw_irw = 0;
    for (int i = 0; i < 4; i++) begin
      if (Mem_Req_O) n++;
      if (IRWrite_O) saw_irw = 1;
      chk("ws_addr", Mem_Addr_O, 32'h3004);
      drive(1, 0, 0, (i == 3), 32'h1111_2222); step();
    end
    chk("ws_req_cycles", n, 4);
    chk("ws_no_early_irw", {31'd0, saw_irw}, 0);
    chk("ws_irw", {31'd0, IRWrite_O}, 1);
    chk("ws_pc",  PC_O, 32'h3008);
    // Fetch sampled during the IRWrite cycle: back-to-back request
    drive(1, 0, 0, 0, 0); step();
    chk("b2b_req",  {31'd0, Mem_Req_O}, 1);
    chk("b2b_addr", Mem_Addr_O, 32'h3008);
    chk("b2b_irw_single", {31'd0, IRWrite_O}, 0);
    drive(0, 0, 0, 1, 32'h3333_4444); step();
    chk("b2b_pc", PC_O, 32'h300C);
    drive(0, 0, 0, 0, 0); step();

    // PCWrite during fetch
    drive(1, 0, 0, 0, 0); step();
    drive(0, 1, 32'h4000, 0, 0); step();
    chk("pw_pc_now", PC_O, 32'h4000);
    chk("pw_addr",   Mem_Addr_O, 32'h300C);
    drive(0, 0, 0, 1, 32'h5555_6666); step();
    chk("pw_pc_done", PC_O, 32'h4000);
    chk("pw_irw",     {31'd0, IRWrite_O}, 1);
    drive(0, 0, 0, 0, 0); step();

    // Misaligned PC
    drive(1, 1, 32'h3002, 0, 0); step();
    chk("mis_req", {31'd0, Mem_Req_O}, 0);
    chk("mis_err", {31'd0, Err_O}, 1);
    drive(1, 0, 0, 0, 0); step();
    chk("mis_sticky", {31'd0, Err_O}, 1);
    chk("mis_noreq",  {31'd0, Mem_Req_O}, 0);
    drive(0, 1, 32'h3008, 0, 0); step();
    chk("mis_clr", {31'd0, Err_O}, 0);
    chk("mis_pc",  PC_O, 32'h3008);
    drive(1, 0, 0, 0, 0); step();
    chk("mis_idle_req", {31'd0, Mem_Req_O}, 1);
    chk("mis_idle_addr", Mem_Addr_O, 32'h3008);
    drive(0, 0, 0, 1, 32'h7); step();
    drive(0, 0, 0, 0, 0); step();

    // Reset asserted mid-REQ
    drive(1, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0);
    #2 Reset_N_I = 1'b0;
    #1;
    chk("arst_req",  {31'd0, Mem_Req_O}, 0);
    chk("arst_pc",   PC_O, 32'h3000);
    chk("arst_addr", Mem_Addr_O, 32'h3000);
    step();
    Reset_N_I = 1'b1;
    drive(0, 0, 0, 1, 32'hDEAD_BEEF); step();
    chk("arst_no_irw", {31'd0, IRWrite_O}, 0);
    chk("arst_ird",    IRData_O, 0);
    drive(0, 0, 0, 0, 0); step();

`ifdef FETCH_TIMEOUT_EN
    // Timeout with no acknowledge
    drive(1, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0);
    n = 0; saw_irw = 0;
    for (int i = 0; i < 10; i++) begin
      if (Mem_Req_O) n++;
      if (IRWrite_O) saw_irw = 1;
      step();
    end
    chk("tmo_req_cycles", n, TMO);
    chk("tmo_err", {31'd0, Err_O}, 1);
    chk("tmo_no_irw", {31'd0, saw_irw}, 0);
    chk("tmo_pc", PC_O, 32'h3000);
    drive(0, 1, 32'h3000, 0, 0); step();
    drive(0, 0, 0, 0, 0); step();
`endif

    // Randomized traffic against the reference model
    Reset_N_I = 1'b0; step();
    Reset_N_I = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      compare_all();
      r    = $urandom;
      f    = ($urandom_range(0, 1) == 1);
      pw   = ($urandom_range(0, 7) == 0);
      ack  = ($urandom_range(0, 9) < 4);
      data = $urandom;
      case ($urandom_range(0, 9))
        0:       npc = {r[31:2], 2'($urandom_range(1, 3))};
        1:       npc = 32'hFFFF_FFFC;
        default: npc = {r[31:2], 2'b00};
      endcase
      drive(f, pw, npc, ack, data);
      model_step(f, pw, npc, ack, data);
      step();
    end
    compare_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch controller for the multi-cycle MIPS-C datapath. It owns the program counter and reads the instruction word at PC from instruction memory over a request/acknowledge handshake. It then drives the instruction register's data and write-enable inputs with a one-cycle write pulse and advances PC. It sits between the control unit's fetch request and the IR, acting as the producer on the IR's write interface.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000: PC value after reset.
- TIMEOUT_CYCLES, 16: maximum cycles in REQ without acknowledge. Used only with FETCH_TIMEOUT_EN.

Ports (one clock; reset is asynchronous and active-low):
- CLK_I  in  1  system clock, all state updates on rising edge.
- Reset_N_I  in  1  asynchronous active-low reset.
- Fetch_I  in  1  control unit requests a fetch at the current PC. Sampled only in IDLE.
- PCWrite_I  in  1  load NPC_I into PC (branch/jump).
- NPC_I  in  32  next PC value.
- Mem_Req_O  out  1  read request to instruction memory.
- Mem_Addr_O  out  32  read address; word aligned.
- Mem_Ack_I  in  1  memory acknowledge; Mem_Data_I is valid in the same cycle.
- Mem_Data_I  in  32  instruction word from memory.
- IRWrite_O  out  1  one-cycle write pulse to the IR.
- IRData_O  out  32  instruction word for the IR.
- PC_O  out  32  current PC.
- PC4_O  out  32  PC_O + 4, combinational.
- Busy_O  out  1  high while a fetch is outstanding (state REQ).
- Err_O  out  1  fetch error flag.

## Operation
States: IDLE, REQ, ERR.

- **IDLE**
  - Effective address = NPC_I if PCWrite_I is high this cycle, else PC.
  - Fetch_I high and effective address[1:0]==0: latch address into Mem_Addr_O, go to REQ.
  - Fetch_I high and address misaligned: go to ERR; no request is issued.
  - PCWrite_I high alone: PC <= NPC_I.
- **REQ**
  - Mem_Req_O is high and Mem_Addr_O is held stable until Mem_Ack_I is sampled high.
  - On acknowledge: IRData_O <= Mem_Data_I, IRWrite_O <= 1 for exactly the next cycle, state <= IDLE.
  - PC update at that same edge:
    - PC <= Mem_Addr_O + 4, unless PCWrite_I was asserted at any time during the fetch or at this edge.
    - In that case the most recent NPC_I wins.
  - PCWrite_I in REQ updates PC immediately but never changes Mem_Addr_O.
  - Fetch_I is ignored in REQ and ERR.
- **ERR**
  - Err_O = 1 (sticky).
  - PCWrite_I high: PC <= NPC_I, Err_O <= 0, state <= IDLE.
- Mem_Ack_I outside REQ is ignored.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 with no error.
- IRData_O holds its last value between fetches.

## Timing
- Reset values:
  - PC_O = RESET_PC, PC4_O = RESET_PC+4.
  - Mem_Addr_O = RESET_PC, Mem_Req_O = 0.
  - IRWrite_O = 0, IRData_O = 0.
  - Busy_O = 0, Err_O = 0, state = IDLE.
- Reset asserted mid-fetch: all outputs return to reset values immediately. No IRWrite_O pulse is produced for the aborted fetch.
- Fetch_I sampled at edge 0 makes Mem_Req_O high after edge 0.
- Acknowledge in the first request cycle raises IRWrite_O after edge 1. Zero-wait-state fetch therefore takes 2 cycles; each wait state adds 1.
- Mem_Req_O drops after the edge that samples acknowledge.
- Earliest next request: Fetch_I may be sampled during the IRWrite_O cycle, giving a new Mem_Req_O one cycle later. Back-to-back throughput is one instruction per 2 cycles.

## Configuration
FETCH_TIMEOUT_EN:
- Defined:
  - A counter clears on entry to REQ and increments each REQ cycle without acknowledge.
  - When it reaches TIMEOUT_CYCLES: Mem_Req_O drops, state goes to ERR, Err_O = 1, PC unchanged.
  - Acknowledge in the same cycle as the limit is treated as success.
- Not defined: no counter; REQ waits indefinitely. Err_O reports misalignment only.

## Structure
- Shared package instr_fetch_pkg holds:
  - state encodings IF_IDLE, IF_REQ, IF_ERR;
  - the default RESET_PC;
  - the timeout counter width $clog2(TIMEOUT_CYCLES+1).
- One sub-module, fetch_timeout_cnt (clear, enable, limit reached), instantiated only under FETCH_TIMEOUT_EN.

## Test plan
- **Reset, then zero-wait fetch.** Release reset, Fetch_I for 1 cycle, ack in the first REQ cycle with data 32'h2408_0005. Expect Mem_Addr_O=32'h3000, IRWrite_O pulse 2 cycles after Fetch_I, IRData_O=32'h2408_0005, PC_O=32'h3004.
- **Wait states.** Ack delayed 3 cycles. Expect Mem_Req_O high for 4 cycles with address stable, a single IRWrite_O pulse, and Fetch_I ignored while Busy_O=1.
- **PCWrite during fetch.** PCWrite_I with NPC_I=32'h4000 during REQ. Expect completion leaves PC_O=32'h4000, not 32'h3004, and the fetched address is unchanged.
- **Misaligned PC.** PCWrite_I with NPC_I=32'h3002 together with Fetch_I. Expect no Mem_Req_O and Err_O=1. A later PCWrite_I of 32'h3008 clears Err_O and returns to IDLE.
- **Timeout (FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4).** Never acknowledge. Expect Mem_Req_O to drop after 4 cycles, Err_O=1, and no IRWrite_O.
- **Reset mid-REQ.** Assert Reset_N_I low during REQ. Expect Mem_Req_O=0 and PC_O=32'h3000 asynchronously, and no IRWrite_O after release.
